// File: rtl/mouse_pkg.sv
// ---------------------------------------------------------------------------
// mouse_pkg : shared types and limits for the mouse-to-analog-stick bridge
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mouse_pkg;
  localparam int POS_MIN = -128;
  localparam int POS_MAX = 127;

  typedef logic signed [7:0] pos_t;
  typedef logic signed [9:0] sum_t;
endpackage

`default_nettype wire

// File: rtl/mouse_axis_acc.sv
// ---------------------------------------------------------------------------
// mouse_axis_acc : one axis of mouse delta scaling, clamping, saturating
// accumulation and decay toward centre
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mouse_axis_acc
  import mouse_pkg::*;
#(
  parameter int SHIFT     = 1,
  parameter int MAX_DELTA = 10,
  parameter bit INVERT    = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       evt,
  input  logic       cancel,
  input  logic       decay_tick,
  input  logic       sign,
  input  logic [7:0] mag,
  output pos_t       pos
);

  localparam sum_t DELTA_LIM = sum_t'(MAX_DELTA);

  logic signed [8:0] w_raw;
  logic signed [8:0] w_shifted;
  sum_t              w_delta_ext;
  sum_t              w_delta_dir;
  sum_t              w_delta;
  sum_t              w_sum;
  pos_t              w_pos_sat;
  pos_t              w_pos_decay;

  always_comb begin
    w_raw       = {sign, mag};
    w_shifted   = w_raw >>> SHIFT;
    // Ten bits so that negating -256 (SHIFT=0) cannot overflow
    w_delta_ext = {w_shifted[8], w_shifted};
    w_delta_dir = INVERT ? -w_delta_ext : w_delta_ext;

    w_delta = w_delta_dir;
    if (w_delta_dir > DELTA_LIM) begin
      w_delta = DELTA_LIM;
    end else if (w_delta_dir < -DELTA_LIM) begin
      w_delta = -DELTA_LIM;
    end

    w_sum = {pos[7], pos[7], pos} + w_delta;
    if (w_sum > sum_t'(POS_MAX)) begin
      w_pos_sat = pos_t'(POS_MAX);
    end else if (w_sum < sum_t'(POS_MIN)) begin
      w_pos_sat = pos_t'(POS_MIN);
    end else begin
      w_pos_sat = w_sum[7:0];
    end

    w_pos_decay = pos;
    if (pos > 8'sd0) begin
      w_pos_decay = pos - 8'sd1;
    end else if (pos < 8'sd0) begin
      w_pos_decay = pos + 8'sd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || cancel) begin
      pos <= '0;
    end else if (evt) begin
      pos <= w_pos_sat;
    end else if (decay_tick) begin
      pos <= w_pos_decay;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mouse_to_analog.sv
// ---------------------------------------------------------------------------
// mouse_to_analog : PS/2 mouse packets to emulated 5200 analog stick and fire
// buttons, arbitrated against the real analog stick
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mouse_to_analog
  import mouse_pkg::*;
#(
  parameter int SHIFT     = 1,
  parameter int MAX_DELTA = 10,
  parameter int INVERT_Y  = 0,
  parameter int DECAY_DIV = 0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [24:0] ps2_mouse,
  input  logic [15:0] joya,
  input  logic        cpu_halt,
  output logic [7:0]  ax,
  output logic [7:0]  ay,
  output logic [1:0]  btn,
  output logic        emu
);

  localparam bit          C_DECAY_EN  = (DECAY_DIV != 0);
  localparam logic [15:0] C_IDLE_LAST = C_DECAY_EN ? 16'(DECAY_DIV - 1) : 16'd0;

  logic        r_stb_d;
  logic        r_emu;
  logic [1:0]  r_btn;
  logic [15:0] r_idle;
  logic        w_event;
  logic        w_cancel;
  logic        w_decay_tick;
  pos_t        w_pos_x;
  pos_t        w_pos_y;
  logic        w_unused;

  assign w_event      = ps2_mouse[24] ^ r_stb_d;
  assign w_cancel     = (joya != 16'd0) || cpu_halt;
  assign w_decay_tick = C_DECAY_EN && r_emu && !w_event && (r_idle == C_IDLE_LAST);
  assign w_unused     = ^{ps2_mouse[7:6], ps2_mouse[3:2]};

  // Strobe copy tracks the bus even in reset, so leaving reset never fires an event
  always_ff @(posedge clk_sys) begin
    r_stb_d <= ps2_mouse[24];
    if (reset || w_cancel) begin
      r_emu  <= 1'b0;
      r_btn  <= 2'b00;
      r_idle <= 16'd0;
    end else if (w_event) begin
      r_emu  <= 1'b1;
      r_btn  <= ps2_mouse[1:0];
      r_idle <= 16'd0;
    end else if (C_DECAY_EN && r_emu) begin
      r_idle <= w_decay_tick ? 16'd0 : r_idle + 16'd1;
    end
  end

  mouse_axis_acc #(
    .SHIFT     (SHIFT),
    .MAX_DELTA (MAX_DELTA),
    .INVERT    (1'b0)
  ) u_acc_x (
    .clk        (clk_sys),
    .reset      (reset),
    .evt        (w_event),
    .cancel     (w_cancel),
    .decay_tick (w_decay_tick),
    .sign       (ps2_mouse[4]),
    .mag        (ps2_mouse[15:8]),
    .pos        (w_pos_x)
  );

  mouse_axis_acc #(
    .SHIFT     (SHIFT),
    .MAX_DELTA (MAX_DELTA),
    .INVERT    (INVERT_Y != 0)
  ) u_acc_y (
    .clk        (clk_sys),
    .reset      (reset),
    .evt        (w_event),
    .cancel     (w_cancel),
    .decay_tick (w_decay_tick),
    .sign       (ps2_mouse[5]),
    .mag        (ps2_mouse[23:16]),
    .pos        (w_pos_y)
  );

  assign ax  = r_emu ? w_pos_x : joya[7:0];
  assign ay  = r_emu ? w_pos_y : joya[15:8];
  assign btn = r_emu ? r_btn : 2'b00;
  assign emu = r_emu;

endmodule

`default_nettype wire

// File: tb/tb_mouse_to_analog.sv
// ---------------------------------------------------------------------------
// tb_mouse_to_analog : self-checking bench for mouse_to_analog
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mouse_to_analog;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [24:0] ps2_mouse;
  logic [15:0] joya;
  logic        cpu_halt;
  logic [7:0]  ax0, ay0, ax1, ay1;
  logic [1:0]  btn0, btn1;
  logic        emu0, emu1;

  int nvec = 0;
  int nerr = 0;

  always #5 clk_sys = ~clk_sys;

  // dut0: no decay; dut1: inverted Y with decay every 4 idle cycles
  mouse_to_analog #(.SHIFT(1), .MAX_DELTA(10), .INVERT_Y(0), .DECAY_DIV(0)) dut0 (
    .clk_sys(clk_sys), .reset(reset), .ps2_mouse(ps2_mouse), .joya(joya),
    .cpu_halt(cpu_halt), .ax(ax0), .ay(ay0), .btn(btn0), .emu(emu0));

  mouse_to_analog #(.SHIFT(1), .MAX_DELTA(10), .INVERT_Y(1), .DECAY_DIV(4)) dut1 (
    .clk_sys(clk_sys), .reset(reset), .ps2_mouse(ps2_mouse), .joya(joya),
    .cpu_halt(cpu_halt), .ax(ax1), .ay(ay1), .btn(btn1), .emu(emu1));

  typedef struct {
    bit       emu;
    int       px;
    int       py;
    bit [1:0] btn;
    int       idle;
    bit       stb_d;
  } mst_t;

  typedef struct {
    int shift;
    int maxd;
    bit inv;
    int ddiv;
  } mpar_t;

  mst_t  m0, m1;
  mpar_t p0 = '{shift: 1, maxd: 10, inv: 1'b0, ddiv: 0};
  mpar_t p1 = '{shift: 1, maxd: 10, inv: 1'b1, ddiv: 4};

  function automatic int mdelta(bit sgn, logic [7:0] mag, mpar_t p, bit is_y);
    int v;
    v = sgn ? int'(mag) - 256 : int'(mag);
    v = v >>> p.shift;
    if (is_y && p.inv) v = -v;
    if (v > p.maxd) v = p.maxd;
    if (v < -p.maxd) v = -p.maxd;
    return v;
  endfunction

  function automatic int msat(int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int toward0(int v);
    if (v > 0) return v - 1;
    if (v < 0) return v + 1;
    return v;
  endfunction

  function automatic mst_t mstep(mst_t s, mpar_t p, logic rst, logic [24:0] m,
                                 logic [15:0] ja, logic halt);
    mst_t n;
    bit   ev;
    n       = s;
    ev      = (m[24] != s.stb_d);
    n.stb_d = m[24];
    if (rst || ja != 16'd0 || halt) begin
      n.emu = 1'b0; n.px = 0; n.py = 0; n.btn = 2'b00; n.idle = 0;
    end else if (ev) begin
      n.emu  = 1'b1;
      n.btn  = m[1:0];
      n.px   = msat(s.px + mdelta(m[4], m[15:8], p, 1'b0));
      n.py   = msat(s.py + mdelta(m[5], m[23:16], p, 1'b1));
      n.idle = 0;
    end else if (p.ddiv != 0 && s.emu) begin
      if (s.idle == p.ddiv - 1) begin
        n.idle = 0;
        n.px   = toward0(s.px);
        n.py   = toward0(s.py);
      end else begin
        n.idle = s.idle + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [7:0] exp_pos(bit e, int pos, logic [7:0] jv);
    return e ? 8'(pos) : jv;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(bit tog, int dx, int dy, bit [1:0] b, logic [15:0] ja,
                       bit halt, bit rst);
    logic [8:0] xd;
    logic [8:0] yd;
    xd = dx[8:0];
    yd = dy[8:0];
    ps2_mouse[24]    = ps2_mouse[24] ^ tog;
    ps2_mouse[15:8]  = xd[7:0];
    ps2_mouse[4]     = xd[8];
    ps2_mouse[23:16] = yd[7:0];
    ps2_mouse[5]     = yd[8];
    ps2_mouse[1:0]   = b;
    joya             = ja;
    cpu_halt         = halt;
    reset            = rst;
  endtask

  // Advance models on the present inputs, clock once, compare on the falling edge
  task automatic tick();
    m0 = mstep(m0, p0, reset, ps2_mouse, joya, cpu_halt);
    m1 = mstep(m1, p1, reset, ps2_mouse, joya, cpu_halt);
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk("m0.ax",  ax0, exp_pos(m0.emu, m0.px, joya[7:0]));
    chk("m0.ay",  ay0, exp_pos(m0.emu, m0.py, joya[15:8]));
    chk("m0.btn", {6'd0, btn0}, {6'd0, m0.emu ? m0.btn : 2'b00});
    chk("m0.emu", {7'd0, emu0}, {7'd0, m0.emu});
    chk("m1.ax",  ax1, exp_pos(m1.emu, m1.px, joya[7:0]));
    chk("m1.ay",  ay1, exp_pos(m1.emu, m1.py, joya[15:8]));
    chk("m1.btn", {6'd0, btn1}, {6'd0, m1.emu ? m1.btn : 2'b00});
    chk("m1.emu", {7'd0, emu1}, {7'd0, m1.emu});
  endtask

  typedef struct {
    bit          tog;
    int          dx;
    int          dy;
    bit [1:0]    b;
    logic [15:0] ja;
    bit          halt;
    logic [7:0]  eax;
    logic [7:0]  eay;
    logic [1:0]  ebtn;
    bit          eemu;
  } tv_t;

  tv_t tv[12];

  initial begin
    int e;
    int dens;
    m0 = '{emu: 1'b0, px: 0, py: 0, btn: 2'b00, idle: 0, stb_d: 1'b0};
    m1 = m0;
    ps2_mouse = 25'h1000000;
    joya      = 16'd0;
    cpu_halt  = 1'b0;
    reset     = 1'b1;

    // Directed vectors for dut0 (SHIFT=1, MAX_DELTA=10), applied in sequence
    tv[0]  = '{1'b0,    0,    0, 2'b00, 16'h1234, 1'b0, 8'h34, 8'h12, 2'b00, 1'b0};
    tv[1]  = '{1'b1,   40,    0, 2'b00, 16'h0000, 1'b0, 8'h0A, 8'h00, 2'b00, 1'b1};
    tv[2]  = '{1'b1,    6,   -7, 2'b10, 16'h0000, 1'b0, 8'h0D, 8'hFC, 2'b10, 1'b1};
    tv[3]  = '{1'b0,    0,    0, 2'b00, 16'h0000, 1'b0, 8'h0D, 8'hFC, 2'b10, 1'b1};
    tv[4]  = '{1'b1, -255,    0, 2'b00, 16'h0000, 1'b0, 8'h03, 8'hFC, 2'b00, 1'b1};
    tv[5]  = '{1'b1,  255,    1, 2'b00, 16'h0000, 1'b0, 8'h0D, 8'hFC, 2'b00, 1'b1};
    tv[6]  = '{1'b1,   40,   40, 2'b11, 16'h0005, 1'b0, 8'h05, 8'h00, 2'b00, 1'b0};
    tv[7]  = '{1'b0,    0,    0, 2'b00, 16'h0000, 1'b0, 8'h00, 8'h00, 2'b00, 1'b0};
    tv[8]  = '{1'b1,    3,    0, 2'b01, 16'h0000, 1'b0, 8'h01, 8'h00, 2'b01, 1'b1};
    tv[9]  = '{1'b0,    0,    0, 2'b01, 16'h0000, 1'b1, 8'h00, 8'h00, 2'b00, 1'b0};
    tv[10] = '{1'b0,    0,    0, 2'b00, 16'h8081, 1'b0, 8'h81, 8'h80, 2'b00, 1'b0};
    tv[11] = '{1'b1,  -20,   20, 2'b11, 16'h0000, 1'b0, 8'hF6, 8'h0A, 2'b11, 1'b1};

    @(negedge clk_sys);
    tick();
    tick();
    chk("rst.emu", {7'd0, emu0}, 8'd0);
    chk("rst.ax",  ax0, 8'h00);

    for (int i = 0; i < 12; i++) begin
      drive(tv[i].tog, tv[i].dx, tv[i].dy, tv[i].b, tv[i].ja, tv[i].halt, 1'b0);
      tick();
      chk($sformatf("tv%0d.ax", i),  ax0, tv[i].eax);
      chk($sformatf("tv%0d.ay", i),  ay0, tv[i].eay);
      chk($sformatf("tv%0d.btn", i), {6'd0, btn0}, {6'd0, tv[i].ebtn});
      chk($sformatf("tv%0d.emu", i), {7'd0, emu0}, {7'd0, tv[i].eemu});
    end

    // Reset together with a packet: everything clears, no later spurious event
    drive(1'b1, 40, 40, 2'b11, 16'h0000, 1'b0, 1'b1);
    tick();
    chk("rstev.emu", {7'd0, emu0}, 8'd0);
    chk("rstev.ax",  ax0, 8'h00);
    drive(1'b0, 0, 0, 2'b00, 16'h0000, 1'b0, 1'b0);
    tick();
    chk("rstev.hold", {7'd0, emu0}, 8'd0);

    // Back-to-back packets of -255 saturate at -128, then +255 saturate at +127
    for (int k = 1; k <= 15; k++) begin
      drive(1'b1, -255, 0, 2'b00, 16'h0000, 1'b0, 1'b0);
      tick();
      e = (-10 * k < -128) ? -128 : -10 * k;
      chk($sformatf("satneg%0d", k), ax0, 8'(e));
    end
    for (int k = 1; k <= 28; k++) begin
      drive(1'b1, 255, 0, 2'b00, 16'h0000, 1'b0, 1'b0);
      tick();
      e = (-128 + 10 * k > 127) ? 127 : -128 + 10 * k;
      chk($sformatf("satpos%0d", k), ax0, 8'(e));
    end

    // Decay on dut1: pos 3 / -3 steps toward 0 every 4 idle cycles
    drive(1'b0, 0, 0, 2'b00, 16'h0000, 1'b0, 1'b1);
    tick();
    drive(1'b1, 6, 6, 2'b00, 16'h0000, 1'b0, 1'b0);
    tick();
    chk("decay.ax0", ax1, 8'h03);
    chk("decay.ay0", ay1, 8'hFD);
    for (int k = 1; k <= 20; k++) begin
      drive(1'b0, 0, 0, 2'b00, 16'h0000, 1'b0, 1'b0);
      tick();
      e = (3 - k / 4 < 0) ? 0 : 3 - k / 4;
      chk($sformatf("decay%0d.ax", k), ax1, 8'(e));
      chk($sformatf("decay%0d.ay", k), ay1, 8'(-e));
    end

    // Randomised traffic with varying packet density, checked against the models
    dens = 1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) dens = 1 << (2 * $urandom_range(3));
      drive($urandom_range(dens - 1) == 0,
            int'($urandom_range(511)), int'($urandom_range(511)),
            2'($urandom_range(3)),
            ($urandom_range(63) == 0) ? 16'($urandom) : 16'h0000,
            $urandom_range(127) == 0,
            $urandom_range(499) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
